// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-8 demux / 8-to-1 mux frame path.
package demux_pkg;
  localparam int unsigned N_CH  = 8;
  localparam int unsigned SEL_W = $clog2(N_CH);

  typedef logic [N_CH-1:0]  frame_t;
  typedef logic [SEL_W-1:0] sel_t;

  localparam frame_t FULL_MASK = '1;

  function automatic frame_t onehot(input sel_t idx);
    return frame_t'(1) << idx;
  endfunction
endpackage

// File: rtl/frame_out_reg.sv
// Single-entry valid/ready holding register; data is stable while valid && !pop.
module frame_out_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         free
);
  assign free = !valid || pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      dout  <= load_data;
      valid <= 1'b1;
    end else if (valid && pop) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/demux1to8_frame.sv
// Sequential 1-to-8 demux: steers accepted samples into an 8-channel frame and
// hands completed frames to a one-deep valid/ready output register.
module demux1to8_frame
  import demux_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [SEL_W-1:0] S,
  input  logic             auto_mode,
  input  logic             flush,
  output logic [N_CH-1:0]  out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovw_err
);
  frame_t col_buf, mask;
  sel_t   cnt;
  logic   pending;

  sel_t   idx;
  logic   accept, complete, slot_free, load;
  frame_t hit, buf_nxt, mask_nxt, load_data;

  assign din_ready = !pending;

  always_comb begin
    idx       = auto_mode ? cnt : S;
    accept    = din_valid && !pending && !flush;
    hit       = accept ? onehot(idx) : '0;
    buf_nxt   = (col_buf & ~hit) | (din ? hit : '0);
    mask_nxt  = mask | hit;
    complete  = accept && (mask_nxt == FULL_MASK);
    // A held frame and a freshly completed one are mutually exclusive, since
    // input is blocked while a frame is pending.
    load      = !flush && slot_free && (pending || complete);
    load_data = pending ? col_buf : buf_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_buf <= '0;
      mask    <= '0;
      cnt     <= '0;
      pending <= 1'b0;
      ovw_err <= 1'b0;
    end else begin
      ovw_err <= accept && !auto_mode && mask[S];
      if (flush || load) begin
        col_buf <= '0;
        mask    <= '0;
        cnt     <= '0;
        pending <= 1'b0;
      end else if (accept) begin
        col_buf <= buf_nxt;
        mask    <= mask_nxt;
        if (auto_mode) cnt <= cnt + 1'b1;
        if (complete) pending <= 1'b1;
      end
    end
  end

  frame_out_reg #(.W(N_CH)) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (load_data),
    .pop       (out_ready),
    .dout      (out),
    .valid     (out_valid),
    .free      (slot_free)
  );
endmodule

// File: tb/tb_demux1to8_frame.sv
// Self-checking bench for demux1to8_frame: frame-level reference model plus
// directed scenarios with hand-computed expectations.
module tb_demux1to8_frame;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic [2:0] S = '0;
  logic       auto_mode = 1'b1;
  logic       flush = 1'b0;
  logic [7:0] out;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       ovw_err;

  int n_checks = 0;
  int n_fail   = 0;

  demux1to8_frame dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .S         (S),
    .auto_mode (auto_mode),
    .flush     (flush),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovw_err   (ovw_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: which channels hold which sample, a held frame, the
  // frame presented downstream.
  bit         m_data[8];
  bit         m_wr[8];
  int         m_cnt;
  bit         m_pend;
  bit [7:0]   m_held;
  bit [7:0]   m_out;
  bit         m_valid;
  bit         m_ovw;
  bit         m_free, m_acc, m_done;
  bit [7:0]   m_frame;
  int         m_ch, m_nwr;

  task automatic clear_frame();
    for (int i = 0; i < 8; i++) begin
      m_data[i] = 1'b0;
      m_wr[i]   = 1'b0;
    end
    m_cnt = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clear_frame();
      m_pend  = 1'b0;
      m_held  = '0;
      m_out   = '0;
      m_valid = 1'b0;
      m_ovw   = 1'b0;
    end else begin
      m_free = !m_valid || out_ready;
      m_acc  = din_valid && !m_pend && !flush;
      m_ovw  = m_acc && !auto_mode && m_wr[S];
      m_done = 1'b0;
      if (flush) begin
        clear_frame();
        m_pend = 1'b0;
      end else if (m_pend) begin
        if (m_free) begin
          m_frame = m_held;
          m_done  = 1'b1;
          m_pend  = 1'b0;
          clear_frame();
        end
      end else if (m_acc) begin
        m_ch = auto_mode ? m_cnt : int'(S);
        m_data[m_ch] = din;
        m_wr[m_ch]   = 1'b1;
        if (auto_mode) m_cnt = (m_cnt + 1) % 8;
        m_nwr = 0;
        for (int i = 0; i < 8; i++) m_nwr += int'(m_wr[i]);
        if (m_nwr == 8) begin
          for (int i = 0; i < 8; i++) m_frame[i] = m_data[i];
          clear_frame();
          if (m_free) m_done = 1'b1;
          else begin
            m_pend = 1'b1;
            m_held = m_frame;
          end
        end
      end
      if (m_done) begin
        m_out   = m_frame;
        m_valid = 1'b1;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_out_valid", 32'(out_valid), 32'(m_valid));
    chk("m_din_ready", 32'(din_ready), 32'(!m_pend));
    chk("m_ovw_err", 32'(ovw_err), 32'(m_ovw));
    if (m_valid) chk("m_out", 32'(out), 32'(m_out));
  end

  task automatic put(input logic d, input logic [2:0] s, input logic a);
    din       = d;
    S         = s;
    auto_mode = a;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic put_frame(input logic [7:0] f);
    for (int i = 0; i < 8; i++) put(f[i], 3'd0, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] t1_bits;
  logic [7:0] frames[4];
  logic [2:0] t2_sel[9];
  logic       t2_din[9];

  initial begin
    // Reset state
    idle(2);
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_din_ready", 32'(din_ready), 32'h1);
    chk("rst_ovw_err", 32'(ovw_err), 32'h0);
    rst_n = 1'b1;
    idle(1);

    // Auto mode, samples 1,0,1,1,0,0,1,0
    out_ready = 1'b1;
    t1_bits = 8'b0100_1101;
    for (int i = 0; i < 8; i++) begin
      put(t1_bits[i], 3'd0, 1'b1);
      chk("t1_din_ready", 32'(din_ready), 32'h1);
      if (i < 7) chk("t1_valid_early", 32'(out_valid), 32'h0);
    end
    chk("t1_out_valid", 32'(out_valid), 32'h1);
    chk("t1_out", 32'(out), 32'h4D);
    idle(1);
    chk("t1_valid_drop", 32'(out_valid), 32'h0);

    // Addressed mode, S = 7..0
    t1_bits = 8'b0011_0011;
    for (int i = 0; i < 8; i++) put(t1_bits[i], 3'(7 - i), 1'b0);
    chk("t2_out_valid", 32'(out_valid), 32'h1);
    chk("t2_out", 32'(out), 32'hCC);
    idle(1);

    // Addressed with S=3 written twice
    t2_sel = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
    t2_din = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      put(t2_din[i], t2_sel[i], 1'b0);
      if (i == 5) chk("t2_ovw_pulse", 32'(ovw_err), 32'h1);
      if (i == 6) chk("t2_ovw_single", 32'(ovw_err), 32'h0);
      if (i == 7) chk("t2_not_complete", 32'(out_valid), 32'h0);
    end
    chk("t2b_out_valid", 32'(out_valid), 32'h1);
    chk("t2b_out", 32'(out), 32'hC4);
    idle(1);

    // Backpressure: two frames with out_ready low
    out_ready = 1'b0;
    put_frame(8'hA5);
    chk("t3_a_valid", 32'(out_valid), 32'h1);
    chk("t3_a_out", 32'(out), 32'hA5);
    for (int i = 0; i < 8; i++) begin
      put(frames_bit(8'h3C, i), 3'd0, 1'b1);
      if (i < 7) chk("t3_ready_during_b", 32'(din_ready), 32'h1);
    end
    chk("t3_ready_drop", 32'(din_ready), 32'h0);
    chk("t3_out_holds_a", 32'(out), 32'hA5);
    idle(2);
    chk("t3_still_stalled", 32'(din_ready), 32'h0);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    chk("t3_b_out", 32'(out), 32'h3C);
    chk("t3_b_valid", 32'(out_valid), 32'h1);
    chk("t3_ready_back", 32'(din_ready), 32'h1);
    idle(2);
    chk("t3_b_stable", 32'(out), 32'h3C);
    out_ready = 1'b1;
    idle(1);
    chk("t3_drained", 32'(out_valid), 32'h0);

    // Flush after 5 samples, together with a 6th
    for (int i = 0; i < 5; i++) put(1'b1, 3'd0, 1'b1);
    din = 1'b1;
    din_valid = 1'b1;
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    din_valid = 1'b0;
    chk("t4_no_frame", 32'(out_valid), 32'h0);
    put_frame(8'h96);
    chk("t4_out_valid", 32'(out_valid), 32'h1);
    chk("t4_out", 32'(out), 32'h96);
    idle(1);

    // Reset mid-frame, between edges
    for (int i = 0; i < 3; i++) put(1'b1, 3'd0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_out_valid", 32'(out_valid), 32'h0);
    chk("t5_out", 32'(out), 32'h0);
    chk("t5_din_ready", 32'(din_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset with a frame pending
    out_ready = 1'b0;
    put_frame(8'hFF);
    put_frame(8'h0F);
    chk("t5_pending", 32'(din_ready), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5p_din_ready", 32'(din_ready), 32'h1);
    chk("t5p_out_valid", 32'(out_valid), 32'h0);
    chk("t5p_out", 32'(out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(4);
    chk("t5_no_emit", 32'(out_valid), 32'h0);

    // Four frames back-to-back
    frames = '{8'h11, 8'hE2, 8'h5B, 8'hC7};
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 8; i++) begin
        put(frames_bit(frames[f], i), 3'd0, 1'b1);
        chk("t6_din_ready", 32'(din_ready), 32'h1);
        if (i == 7) begin
          chk("t6_valid", 32'(out_valid), 32'h1);
          chk("t6_out", 32'(out), 32'(frames[f]));
        end else begin
          chk("t6_gap", 32'(out_valid), 32'h0);
        end
      end
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic logic frames_bit(input logic [7:0] f, input int i);
    return f[i];
  endfunction
endmodule

// File: doc/demux1to8_frame.md
Name: demux1to8_frame

Overview:
- Sequential 1-to-8 demultiplexer and frame collector, the receive end of the 8-to-1 select mux path.
- Takes single-bit samples and steers each into output channel I0..I7 of an 8-bit frame.
- Channel choice comes from an internal rotating counter (auto mode) or from an explicit 3-bit select (addressed mode).
- A completed 8-channel frame goes out on a valid/ready interface, with one frame of buffering so input can continue while output stalls.

Parameters:
- N_CH, 8, number of output channels; fixed at 8 for this revision.
- SEL_W, 3, select width; must equal clog2(N_CH).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  1  sample bit to route.
- din_valid  input  1  din is presented this cycle.
- din_ready  output  1  block accepts din this cycle; a sample is accepted when din_valid && din_ready.
- S  input  SEL_W  target channel in addressed mode; ignored in auto mode.
- auto_mode  input  1  1 = channel from internal counter; 0 = channel from S.
- flush  input  1  synchronous abort of the partially collected frame.
- out  output  N_CH  completed frame; out[k] = sample routed to channel k.
- out_valid  output  1  out holds an unconsumed frame.
- out_ready  input  1  consumer takes the frame when out_valid && out_ready.
- ovw_err  output  1  one-cycle pulse: addressed write hit a channel already written in the current frame.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out=0, out_valid=0, ovw_err=0, din_ready=1.
  - Internal collect buffer=0, channel mask=0, counter=0, pending=0.
- Channel index: idx = auto_mode ? cnt : S.
- On an accepted sample:
  - buf[idx] <= din; mask[idx] <= 1.
  - Auto mode: cnt <= cnt+1, wrapping 7->0.
- Addressed overwrite: if auto_mode=0 and mask[S] is already 1, the data is overwritten, the mask is unchanged and ovw_err pulses high the next cycle. The write still counts as accepted.
- Frame complete when mask becomes 8'hFF, including the write that completes it. The output slot is free when !out_valid || out_ready.
  - Slot free at that edge: out <= completed frame; out_valid <= 1 at the same edge. Latency is 1 cycle from final accepted sample to out_valid. Mask and cnt clear to 0.
  - Slot not free: frame is held in buf, pending <= 1, din_ready = 0.
  - Pending frame moves to out on the first edge where the slot is free. It then clears mask, cnt and pending; din_ready returns to 1 the following cycle.
- din_ready = !pending (combinational from the register). Back-to-back frames sustain 1 sample/cycle with out_ready held high.
- Output: out_valid drops after a handshake unless a new frame loads at the same edge. out is stable while out_valid && !out_ready.
- flush (priority over a same-cycle accepted sample):
  - Clears mask, cnt, buf and pending.
  - Does not touch out/out_valid; a frame already presented survives.
  - A sample presented with flush is dropped.
- Mode switch mid-frame is allowed. Mask keeps tracking, and cnt continues from its value, so auto mode may then hit already-written channels. Those are silent overwrites, with no ovw_err in auto mode.
- Reset mid-frame discards everything with no output.

Decomposition:
- Shared package demux_pkg: N_CH, SEL_W, FULL_MASK = {N_CH{1'b1}}.
- Optional sub-module frame_out_reg: single-entry valid/ready holding register, also reusable on the mux side.
- The collect logic (buf, mask, cnt, pending) stays in the top module.

Test Plan:
- Reset then auto mode, out_ready=1, samples 1,0,1,1,0,0,1,0 on consecutive cycles:
  - out_valid high the cycle after the 8th sample.
  - out=8'b01001101 (out[0]=1).
  - din_ready never drops.
- Addressed mode, S = 7,6,...,0 with din=1,1,0,0,1,1,0,0:
  - out=8'b11001100 after the last write.
  - Repeat with S=3 twice: ovw_err pulses once, and the frame completes only after all 8 channels are written.
- Backpressure: out_ready=0, stream two full frames A=8'hA5 then B=8'h3C in auto mode.
  - out holds A.
  - din_ready drops the cycle after B's 8th sample.
  - Raise out_ready for 1 cycle: out becomes B next cycle and din_ready returns to 1.
- Flush: auto mode, 5 samples then flush together with a 6th sample.
  - mask and cnt return to 0 and the 6th sample is lost.
  - The next 8 samples form the frame, so out equals only those.
- Reset mid-frame and with pending=1:
  - Assert rst_n low asynchronously, between edges.
  - out_valid=0, out=0, din_ready=1 immediately.
  - No frame is emitted after release.
- Wrap and throughput: 4 frames back-to-back with out_ready=1.
  - One frame every 8 cycles; cnt wraps 7->0 with no bubble.
